uart_baud_ctrl: RTL and testbench



---
 rtl/uart_baud_ctrl_if.sv | 27 ++
 rtl/uart_baud_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_baud_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_ctrl_if.sv
// Config/status bundle between the register block, the baud controller and
// the uart_rx/uart_tx tick inputs.
interface uart_baud_ctrl_if #(
  parameter int unsigned DVSR_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DVSR_W-1:0] cfg_dvsr;
  logic              cfg_en;
  logic              rx_busy;
  logic              tx_busy;
  logic              s_tick;
  logic [DVSR_W-1:0] active_dvsr;
  logic              running;
  logic              cfg_err;
  logic              cfg_forced;

  modport master (
    output cfg_valid, cfg_dvsr, cfg_en, rx_busy, tx_busy,
    input  cfg_ready, s_tick, active_dvsr, running, cfg_err, cfg_forced
  );

  modport slave (
    input  cfg_valid, cfg_dvsr, cfg_en, rx_busy, tx_busy,
    output cfg_ready, s_tick, active_dvsr, running, cfg_err, cfg_forced
  );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Programmable oversampling tick generator; divisor/enable changes are held
// back until both UART paths are idle so no character is cut mid-frame.
module uart_baud_ctrl #(
  parameter int unsigned        DVSR_W       = 16,
  parameter logic [DVSR_W-1:0]  DEFAULT_DVSR = 3,
  parameter int unsigned        DRAIN_MAX    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_baud_ctrl_if.slave   bus
);

  localparam int unsigned          DRAIN_W     = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST  = DRAIN_W'((DRAIN_MAX == 0) ? 0 : DRAIN_MAX - 1);
  localparam bit                   HAS_TIMEOUT = (DRAIN_MAX != 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STOP  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [DVSR_W-1:0]   cnt_q,        cnt_d;
  logic [DVSR_W-1:0]   dvsr_q,       dvsr_d;
  logic                en_q,         en_d;
  logic [DVSR_W-1:0]   pend_dvsr_q,  pend_dvsr_d;
  logic                pend_en_q,    pend_en_d;
  logic [DRAIN_W-1:0]  drain_cnt_q,  drain_cnt_d;
  logic                cfg_err_q,    cfg_err_d;
  logic                cfg_forced_q, cfg_forced_d;

  logic                count_en_s;
  logic                tick_s;
  logic                lines_idle_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= {DVSR_W{1'b0}};
      dvsr_q       <= DEFAULT_DVSR;
      en_q         <= 1'b1;
      pend_dvsr_q  <= DEFAULT_DVSR;
      pend_en_q    <= 1'b1;
      drain_cnt_q  <= {DRAIN_W{1'b0}};
      cfg_err_q    <= 1'b0;
      cfg_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvsr_q       <= dvsr_d;
      en_q         <= en_d;
      pend_dvsr_q  <= pend_dvsr_d;
      pend_en_q    <= pend_en_d;
      drain_cnt_q  <= drain_cnt_d;
      cfg_err_q    <= cfg_err_d;
      cfg_forced_q <= cfg_forced_d;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d      = state_q;
    dvsr_d       = dvsr_q;
    en_d         = en_q;
    pend_dvsr_d  = pend_dvsr_q;
    pend_en_d    = pend_en_q;
    drain_cnt_d  = drain_cnt_q;
    cfg_err_d    = 1'b0;
    cfg_forced_d = 1'b0;
    lines_idle_s = !bus.rx_busy && !bus.tx_busy;

    // While draining the old rate keeps ticking so an in-flight frame completes.
    count_en_s = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && en_q);
    tick_s     = count_en_s && (cnt_q == (dvsr_q - DVSR_W'(1)));

    if (!count_en_s) begin
      cnt_d = {DVSR_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {DVSR_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DVSR_W'(1);
    end

    case (state_q)
      ST_RUN, ST_STOP: begin
        if (!bus.cfg_valid) begin
          state_d = state_q;
        end else if (bus.cfg_dvsr == {DVSR_W{1'b0}}) begin
          cfg_err_d = 1'b1;
        end else begin
          pend_dvsr_d = bus.cfg_dvsr;
          pend_en_d   = bus.cfg_en;
          drain_cnt_d = {DRAIN_W{1'b0}};
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lines_idle_s) begin
          state_d = ST_APPLY;
        end else if (HAS_TIMEOUT && (drain_cnt_q == DRAIN_LAST)) begin
          state_d      = ST_APPLY;
          cfg_forced_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_APPLY: begin
        dvsr_d = pend_dvsr_q;
        en_d   = pend_en_q;
        if (pend_en_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.s_tick      = tick_s;
  assign bus.cfg_ready   = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign bus.running     = (state_q == ST_RUN);
  assign bus.active_dvsr = dvsr_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.cfg_forced  = cfg_forced_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Drives two controllers (no drain timeout / 8-cycle timeout) with identical
// stimulus and compares both against a cycle-age reference model.
module tb_uart_baud_ctrl;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_APPLY = 2;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid   = 1'b0;
  logic [15:0] dvsr    = 16'd0;
  logic        en      = 1'b0;
  logic        rx      = 1'b0;
  logic        tx      = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model per instance: rate is a function of cycles elapsed since last apply.
  int m_dm     [2];
  int m_phase  [2];
  int m_period [2];
  int m_age    [2];
  int m_pdvsr  [2];
  int m_drain  [2];
  bit m_en     [2];
  bit m_pen    [2];
  bit m_err    [2];
  bit m_forced [2];

  uart_baud_ctrl_if #(.DVSR_W(16)) bus0 ();
  uart_baud_ctrl_if #(.DVSR_W(16)) bus8 ();

  assign bus0.cfg_valid = valid;
  assign bus0.cfg_dvsr  = dvsr;
  assign bus0.cfg_en    = en;
  assign bus0.rx_busy   = rx;
  assign bus0.tx_busy   = tx;
  assign bus8.cfg_valid = valid;
  assign bus8.cfg_dvsr  = dvsr;
  assign bus8.cfg_en    = en;
  assign bus8.rx_busy   = rx;
  assign bus8.tx_busy   = tx;

  uart_baud_ctrl #(.DVSR_W(16), .DEFAULT_DVSR(16'd3), .DRAIN_MAX(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  uart_baud_ctrl #(.DVSR_W(16), .DEFAULT_DVSR(16'd3), .DRAIN_MAX(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dm=%0d]: observed %0h expected %0h", tag, m_dm[inst], obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i]  = P_IDLE;
      m_period[i] = 3;
      m_age[i]    = 0;
      m_en[i]     = 1'b1;
      m_err[i]    = 1'b0;
      m_forced[i] = 1'b0;
      m_drain[i]  = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic        tick, rdy, run, err, frc, exp_tick;
      logic [15:0] act;
      if (i == 0) begin
        tick = bus0.s_tick; rdy = bus0.cfg_ready; run = bus0.running;
        err  = bus0.cfg_err; frc = bus0.cfg_forced; act = bus0.active_dvsr;
      end else begin
        tick = bus8.s_tick; rdy = bus8.cfg_ready; run = bus8.running;
        err  = bus8.cfg_err; frc = bus8.cfg_forced; act = bus8.active_dvsr;
      end
      exp_tick = (m_phase[i] != P_APPLY) && m_en[i] && ((m_age[i] % m_period[i]) == (m_period[i] - 1));
      check("s_tick",      i, 32'(tick), 32'(exp_tick));
      check("cfg_ready",   i, 32'(rdy),  32'(m_phase[i] == P_IDLE));
      check("running",     i, 32'(run),  32'((m_phase[i] == P_IDLE) && m_en[i]));
      check("active_dvsr", i, 32'(act),  32'(m_period[i]));
      check("cfg_err",     i, 32'(err),  32'(m_err[i]));
      check("cfg_forced",  i, 32'(frc),  32'(m_forced[i]));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit nerr, nforced, was_apply;
      nerr = 1'b0; nforced = 1'b0;
      was_apply = (m_phase[i] == P_APPLY);
      case (m_phase[i])
        P_IDLE: begin
          if (valid && dvsr == 16'd0) begin
            nerr = 1'b1;
          end else if (valid) begin
            m_pdvsr[i] = int'(dvsr);
            m_pen[i]   = en;
            m_drain[i] = 0;
            m_phase[i] = P_DRAIN;
          end
        end
        P_DRAIN: begin
          m_drain[i]++;
          if (!rx && !tx) begin
            m_phase[i] = P_APPLY;
          end else if (m_dm[i] != 0 && m_drain[i] >= m_dm[i]) begin
            m_phase[i] = P_APPLY;
            nforced    = 1'b1;
          end
        end
        default: begin
          m_period[i] = m_pdvsr[i];
          m_en[i]     = m_pen[i];
          m_phase[i]  = P_IDLE;
        end
      endcase
      m_age[i]    = was_apply ? 0 : m_age[i] + 1;
      m_err[i]    = nerr;
      m_forced[i] = nforced;
    end
  endtask

  task automatic cycle();
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic req(input logic [15:0] d, input logic e);
    valid = 1'b1; dvsr = d; en = e;
    cycle();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    m_dm[0] = 0;
    m_dm[1] = 8;
    #3;
    do_reset();
    run(12);

    req(16'd10, 1'b1);
    run(30);

    tx = 1'b1;
    req(16'd5, 1'b1);
    run(20);
    tx = 1'b0;
    run(20);

    rx = 1'b1;
    req(16'd4, 1'b1);
    run(20);
    rx = 1'b0;
    run(16);

    req(16'd0, 1'b1);
    run(10);

    req(16'd6, 1'b0);
    run(10);
    req(16'd1, 1'b1);
    run(10);

    tx = 1'b1;
    req(16'd7, 1'b1);
    run(3);
    do_reset();
    tx = 1'b0;
    run(12);

    // Random traffic, including requests held while the controller is busy.
    for (int k = 0; k < 400; k++) begin
      valid = ($urandom_range(0, 3) == 0);
      dvsr  = 16'($urandom_range(0, 12));
      en    = ($urandom_range(0, 4) != 0);
      if ((k % 60) < 14) begin
        rx = 1'b1;
        tx = ($urandom_range(0, 1) == 0);
      end else begin
        rx = ($urandom_range(0, 2) == 0);
        tx = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    valid = 1'b0; rx = 1'b0; tx = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
